// File: rtl/event_encoder_8to3_pkg.sv
// Shared constants, FSM state type and helpers for the 8-to-3 event encoder.
package event_encoder_8to3_pkg;

    localparam int N_EV   = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    function automatic logic [N_EV-1:0] onehot(input logic [CODE_W-1:0] c);
        return N_EV'(1) << c;
    endfunction

endpackage

// File: rtl/event_encoder_8to3_rr_pick8.sv
// Combinational picker: lowest set index (fixed) or first set index at/after ptr
// searching cyclically (round-robin).
module event_encoder_8to3_rr_pick8
    import event_encoder_8to3_pkg::*;
(
    input  logic [N_EV-1:0]   vec_i,
    input  logic [CODE_W-1:0] ptr_i,
    input  logic              mode_i,
    output logic              found_o,
    output logic [CODE_W-1:0] code_o
);

    logic [CODE_W-1:0]   base;
    logic [2*N_EV-1:0]   dbl;
    logic [N_EV-1:0]     rot;
    logic [CODE_W-1:0]   off;

    // Rotate so the search start lands at bit 0, then find the lowest set bit.
    always_comb begin
        base = mode_i ? ptr_i : '0;
        dbl  = {vec_i, vec_i} >> base;
        rot  = dbl[N_EV-1:0];
        off  = '0;
        for (int i = N_EV - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = CODE_W'(i);
            end
        end
        found_o = |vec_i;
        code_o  = base + off;
    end

endmodule

// File: rtl/event_encoder_8to3.sv
// Event encoder: latches up to 8 event lines as pending and serves them one at a
// time as 3-bit codes over valid/ready, with fixed or round-robin arbitration.
module event_encoder_8to3
    import event_encoder_8to3_pkg::*;
#(
    parameter int MODE_RR = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_EV-1:0]   req_in,
    input  logic              clr,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [CODE_W-1:0] code_out,
    output logic [N_EV-1:0]   pending,
    output logic              overflow
);

    localparam logic MODE_BIT = (MODE_RR != 0);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_EV-1:0]   pend_q, pend_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic [N_EV-1:0]   mask;
    logic [N_EV-1:0]   rem;
    logic [CODE_W-1:0] nxt_ptr;
    logic              found_p, found_r;
    logic [CODE_W-1:0] code_p, code_r;

    always_comb begin
        accept  = (state_q == ST_OFFER) && ready_in;
        mask    = accept ? onehot(code_q) : '0;
        rem     = pend_q & ~mask;
        nxt_ptr = code_q + CODE_W'(1);
    end

    event_encoder_8to3_rr_pick8 u_pick_pend (
        .vec_i  (pend_q),
        .ptr_i  (rr_ptr_q),
        .mode_i (MODE_BIT),
        .found_o(found_p),
        .code_o (code_p)
    );

    // Follow-on pick after an accept searches from just past the served code.
    event_encoder_8to3_rr_pick8 u_pick_rem (
        .vec_i  (rem),
        .ptr_i  (nxt_ptr),
        .mode_i (MODE_BIT),
        .found_o(found_r),
        .code_o (code_r)
    );

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        rr_ptr_d = rr_ptr_q;
        pend_d   = rem | req_in;
        ovf_d    = ovf_q | (|(req_in & rem));
        unique case (state_q)
            ST_IDLE: begin
                if (found_p) begin
                    code_d  = code_p;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (ready_in) begin
                    rr_ptr_d = nxt_ptr;
                    if (found_r) begin
                        code_d = code_r;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
        if (clr) begin
            pend_d   = '0;
            ovf_d    = 1'b0;
            rr_ptr_d = '0;
            state_d  = ST_IDLE;
            code_d   = code_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            rr_ptr_q <= '0;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            rr_ptr_q <= rr_ptr_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
        end
    end

    assign valid_out = (state_q == ST_OFFER);
    assign code_out  = code_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Scoreboard bench: fixed-priority and round-robin encoders driven in parallel
// against a behavioural event-queue model.
module tb_event_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_in;
    logic       clr;
    logic       ready_in;

    logic [1:0] vld;
    logic [2:0] code_fp, code_rr;
    logic [7:0] pend_fp, pend_rr;
    logic [1:0] ovf;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    event_encoder_8to3 #(.MODE_RR(0)) dut_fp (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .clr      (clr),
        .ready_in (ready_in),
        .valid_out(vld[0]),
        .code_out (code_fp),
        .pending  (pend_fp),
        .overflow (ovf[0])
    );

    event_encoder_8to3 #(.MODE_RR(1)) dut_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .clr      (clr),
        .ready_in (ready_in),
        .valid_out(vld[1]),
        .code_out (code_rr),
        .pending  (pend_rr),
        .overflow (ovf[1])
    );

    typedef struct {
        bit       v;
        int       code;
        bit [7:0] pend;
        bit       ovf;
    } rec_t;

    rec_t exp_fp[$];
    rec_t exp_rr[$];
    int   acc_fp[$];
    int   acc_rr[$];

    // Model state, index 0 = fixed priority, 1 = round-robin
    bit [7:0] m_pend[2];
    bit       m_busy[2];
    int       m_code[2];
    int       m_ptr[2];
    bit       m_ovf[2];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit [7:0] v, input int start, input bit rr);
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = rr ? (start + i) % 8 : i;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0;
            m_busy[m] = 1'b0;
            m_code[m] = 0;
            m_ptr[m]  = 0;
            m_ovf[m]  = 1'b0;
        end
    endtask

    // Advance the model across one rising edge using the inputs held before it.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit [7:0] r;
            int       p;
            if (!rst_n) begin
                m_pend[m] = '0; m_busy[m] = 0; m_code[m] = 0;
                m_ptr[m] = 0;   m_ovf[m] = 0;
            end else if (clr) begin
                m_pend[m] = '0; m_busy[m] = 0; m_ptr[m] = 0; m_ovf[m] = 0;
            end else begin
                r = m_pend[m];
                if (m_busy[m] && ready_in) r[m_code[m]] = 1'b0;
                if ((req_in & r) != 0) m_ovf[m] = 1'b1;
                if (!m_busy[m]) begin
                    p = pick(m_pend[m], m_ptr[m], m == 1);
                    if (p >= 0) begin
                        m_code[m] = p;
                        m_busy[m] = 1'b1;
                    end
                end else if (ready_in) begin
                    m_ptr[m] = (m_code[m] + 1) % 8;
                    p = pick(r, m_ptr[m], m == 1);
                    if (p >= 0) m_code[m] = p;
                    else m_busy[m] = 1'b0;
                end
                m_pend[m] = r | req_in;
            end
        end
    endtask

    task automatic push_recs();
        rec_t r;
        for (int m = 0; m < 2; m++) begin
            r.v = m_busy[m]; r.code = m_code[m];
            r.pend = m_pend[m]; r.ovf = m_ovf[m];
            if (m == 0) exp_fp.push_back(r);
            else        exp_rr.push_back(r);
            if (m_busy[m] && ready_in && rst_n) begin
                if (m == 0) acc_fp.push_back(m_code[m]);
                else        acc_rr.push_back(m_code[m]);
            end
        end
    endtask

    task automatic drive(input bit rst, input bit [7:0] req, input bit c, input bit rdy);
        bit was_run;
        @(posedge clk);
        model_step();
        #1;
        was_run = rst_n;
        rst_n = rst; req_in = req; clr = c; ready_in = rdy;
        if (was_run && !rst) begin
            #1;
            chk("async_rst_valid_fp", vld[0], 0);
            chk("async_rst_valid_rr", vld[1], 0);
            chk("async_rst_pend_fp", pend_fp, 0);
            chk("async_rst_pend_rr", pend_rr, 0);
        end
        if (!rst_n) model_reset();
        push_recs();
    endtask

    task automatic cmp_rec(input string tag, input rec_t r, input bit v,
                           input bit [2:0] c, input bit [7:0] p, input bit o);
        chk({tag, "_valid"}, v, r.v);
        chk({tag, "_code"}, c, r.code);
        chk({tag, "_pending"}, p, r.pend);
        chk({tag, "_overflow"}, o, r.ovf);
    endtask

    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge clk);
            if (exp_fp.size() > 0) begin
                r = exp_fp.pop_front();
                cmp_rec("fp", r, vld[0], code_fp, pend_fp, ovf[0]);
            end
            if (exp_rr.size() > 0) begin
                r = exp_rr.pop_front();
                cmp_rec("rr", r, vld[1], code_rr, pend_rr, ovf[1]);
            end
            if (vld[0] && ready_in && rst_n) begin
                if (acc_fp.size() == 0) chk("fp_unexpected_accept", 1, 0);
                else chk("fp_accept_code", code_fp, acc_fp.pop_front());
            end
            if (vld[1] && ready_in && rst_n) begin
                if (acc_rr.size() == 0) chk("rr_unexpected_accept", 1, 0);
                else chk("rr_accept_code", code_rr, acc_rr.pop_front());
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0; req_in = '0; clr = 1'b0; ready_in = 1'b0;
        model_reset();
        #3;
        chk("reset_valid_fp", vld[0], 0);
        chk("reset_valid_rr", vld[1], 0);
        chk("reset_code_fp", code_fp, 0);
        chk("reset_code_rr", code_rr, 0);
        chk("reset_ovf_fp", ovf[0], 0);
        chk("reset_ovf_rr", ovf[1], 0);
        drive(0, 8'h00, 0, 0);
        drive(1, 8'h00, 0, 0);

        // single event, code 5 two edges later
        drive(1, 8'h20, 0, 1);
        repeat (4) drive(1, 8'h00, 0, 1);

        // burst 0xA5
        drive(1, 8'hA5, 0, 1);
        repeat (6) drive(1, 8'h00, 0, 1);

        // hold code under backpressure while bit 0 arrives
        drive(0, 8'h00, 0, 0);
        drive(1, 8'h20, 0, 0);
        drive(1, 8'h00, 0, 0);
        repeat (4) drive(1, 8'h01, 0, 0);
        repeat (4) drive(1, 8'h00, 0, 1);

        // round-robin wrap 7 -> 0
        drive(0, 8'h00, 0, 0);
        drive(1, 8'h40, 0, 0);
        drive(1, 8'h00, 0, 0);
        drive(1, 8'h81, 0, 0);
        repeat (4) drive(1, 8'h00, 0, 1);

        // overflow, accept/arrive same bit, clr
        drive(1, 8'h08, 0, 0);
        drive(1, 8'h08, 0, 0);
        drive(1, 8'h00, 0, 0);
        drive(1, 8'h00, 0, 1);
        drive(1, 8'h00, 1, 0);
        drive(1, 8'h08, 0, 0);
        drive(1, 8'h00, 0, 0);
        drive(1, 8'h08, 0, 1);
        repeat (3) drive(1, 8'h00, 0, 1);
        drive(1, 8'h0C, 1, 0);
        drive(1, 8'h00, 0, 1);

        // reset while offering
        drive(1, 8'h10, 0, 0);
        drive(1, 8'h00, 0, 0);
        drive(0, 8'h00, 0, 0);
        repeat (3) drive(1, 8'h00, 0, 1);

        for (int i = 0; i < 400; i++) begin
            bit [7:0] rq;
            bit       rs;
            rq = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            rs = ($urandom_range(96) != 0);
            drive(rs, rq, $urandom_range(49) == 0, $urandom_range(2) != 0);
        end

        repeat (12) drive(1, 8'h00, 0, 1);
        @(negedge clk);
        #1;
        chk("fp_accepts_drained", acc_fp.size(), 0);
        chk("rr_accepts_drained", acc_rr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
